// File: rtl/mul_pkg.sv
// Shared encodings for the sequential multiplier: op codes, FSM states and a parameter check.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic bit width_ok(input int width, input int step);
        return (width > 0) && (step > 0) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/mul_operand_cond.sv
// Operand conditioning: per-op sign flags and unsigned magnitudes of a and b.
// Purely combinational; the most-negative value maps to 2^(WIDTH-1).
module mul_operand_cond
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             sa,
    output logic             sb
);

    always_comb begin
        sa    = a[WIDTH-1] & ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU));
        sb    = b[WIDTH-1] & (op == MUL_OP_MULH);
        mag_a = sa ? (-a) : a;
        mag_b = sb ? (-b) : b;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add RV32M multiplier retiring STEP multiplier bits per cycle; out_valid rises WIDTH/STEP edges after accept.
// One op in flight; the result is held in DONE until out_ready, flush discards anything in flight.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (!width_ok(WIDTH, STEP)) begin : g_bad_cfg
            $error("seq_multiplier: WIDTH must be a positive multiple of STEP");
        end
    endgenerate

    mul_state_t         state, state_next;
    logic               accept, last;
    logic               low_half, neg;
    logic [2*WIDTH-1:0] a_sh, acc, partial, acc_next, fin;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   c_mag_a, c_mag_b;
    logic               c_sa, c_sb;

    mul_operand_cond #(.WIDTH(WIDTH)) u_cond (
        .op    (op),
        .a     (a),
        .b     (b),
        .mag_a (c_mag_a),
        .mag_b (c_mag_b),
        .sa    (c_sa),
        .sb    (c_sb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Flush wins over everything, including the final CALC edge, so no partial result escapes.
        if (flush) begin
            state_next = IDLE;
            last       = 1'b0;
        end
    end

    // a_sh carries |a| pre-shifted to the weight of the current multiplier chunk.
    always_comb begin
        partial = '0;
        for (int i = 0; i < STEP; i++) begin
            if (b_sh[i]) partial = partial + (a_sh << i);
        end
        acc_next = acc + partial;
        fin      = neg ? (-acc_next) : acc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_half <= 1'b0;
            neg      <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            product  <= '0;
            result   <= '0;
        end else if (accept) begin
            low_half <= (op == MUL_OP_MUL);
            neg      <= c_sa ^ c_sb;
            a_sh     <= {{WIDTH{1'b0}}, c_mag_a};
            b_sh     <= c_mag_b;
            acc      <= '0;
            cnt      <= '0;
        end else if (state == CALC && !flush) begin
            acc  <= acc_next;
            a_sh <= a_sh << STEP;
            b_sh <= b_sh >> STEP;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                product <= fin;
                result  <= low_half ? fin[WIDTH-1:0] : fin[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: a STEP=1 and a STEP=4 instance, directed vector table, corner sequences and random ops vs an arithmetic model.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst, flush, out_ready;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        iv1, iv4;
    logic        ir1, ir4, ov1, ov4;
    logic [31:0] res1, res4;
    logic [63:0] prod1, prod4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op), .a(a), .b(b),
        .flush(flush), .out_valid(ov1), .out_ready(out_ready), .result(res1), .product(prod1)
    );

    seq_multiplier #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op), .a(a), .b(b),
        .flush(flush), .out_valid(ov4), .out_ready(out_ready), .result(res4), .product(prod4)
    );

    typedef struct {
        int          w;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
        logic [31:0] r;
    } vec_t;

    // Reference: extend each operand according to its signedness for the op, multiply, keep 64 bits.
    function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [65:0] xs, ys, p;
        xs = (o == 2'b01 || o == 2'b10) ? {{34{x[31]}}, x} : {34'b0, x};
        ys = (o == 2'b01) ? {{34{y[31]}}, y} : {34'b0, y};
        p  = xs * ys;
        return p[63:0];
    endfunction

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [63:0] p);
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 4) ? ir4 : ir1;
    endfunction
    function automatic logic get_ov(input int w);
        return (w == 4) ? ov4 : ov1;
    endfunction
    function automatic logic [63:0] get_prod(input int w);
        return (w == 4) ? prod4 : prod1;
    endfunction
    function automatic logic [31:0] get_res(input int w);
        return (w == 4) ? res4 : res1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iv(input int w, input logic v);
        if (w == 4) iv4 = v;
        else        iv1 = v;
    endtask

    task automatic start_op(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a  = x;
        b  = y;
        set_iv(w, 1'b1);
        chk("accept_ready", 64'(get_ir(w)), 64'd1);
        tick();
        set_iv(w, 1'b0);
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic wait_done(input int w, output int lat);
        logic ir_seen;
        ir_seen = 1'b0;
        lat     = 0;
        while (!get_ov(w) && lat < 200) begin
            if (get_ir(w)) ir_seen = 1'b1;
            tick();
            lat++;
        end
        chk("ready_low_in_calc", 64'(ir_seen), 64'd0);
        chk("ready_low_in_done", 64'(get_ir(w)), 64'd0);
    endtask

    task automatic take_result(input int w);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_take", 64'({get_ov(w), get_ir(w)}), 64'b01);
    endtask

    task automatic run_check(input string tag, input int w, input logic [1:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [63:0] ep, input logic [31:0] er);
        int lat;
        start_op(w, o, x, y);
        wait_done(w, lat);
        chk({tag, ".latency"}, 64'(lat), (w == 4) ? 64'd8 : 64'd32);
        chk({tag, ".product"}, get_prod(w), ep);
        chk({tag, ".result"}, 64'(get_res(w)), 64'(er));
        take_result(w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[10];
        logic [63:0] hold_p, ep;
        logic [31:0] hold_r;
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int          lat, pulses;

        // MUL captures no sign, so its full product is the unsigned one; only the low half is meaningful.
        tv[0] = '{1, 2'b00, 32'd7,         32'hFFFFFFFD, 64'h00000006_FFFFFFEB, 32'hFFFFFFEB};
        tv[1] = '{1, 2'b01, 32'h80000000,  32'h80000000, 64'h40000000_00000000, 32'h40000000};
        tv[2] = '{1, 2'b11, 32'h80000000,  32'h80000000, 64'h40000000_00000000, 32'h40000000};
        tv[3] = '{1, 2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'hFFFFFFFF_00000001, 32'hFFFFFFFF};
        tv[4] = '{1, 2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 32'hFFFFFFFE};
        tv[5] = '{4, 2'b11, 32'h12345678,  32'h9ABCDEF0, 64'h0B00EA4E_242D2080, 32'h0B00EA4E};
        tv[6] = '{1, 2'b00, 32'd0,         32'd0,        64'h0,                 32'h0};
        tv[7] = '{1, 2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'h00000000_00000001, 32'h00000000};
        tv[8] = '{4, 2'b01, 32'h80000000,  32'd1,        64'hFFFFFFFF_80000000, 32'hFFFFFFFF};
        tv[9] = '{4, 2'b10, 32'h80000000,  32'h80000000, 64'hC0000000_00000000, 32'hC0000000};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        iv1 = 1'b0; iv4 = 1'b0; op = 2'b00; a = '0; b = '0;
        tick();
        tick();
        chk("reset.dut1_ctrl", 64'({ov1, ir1}), 64'b01);
        chk("reset.dut1_prod", prod1, 64'h0);
        chk("reset.dut1_res", 64'(res1), 64'h0);
        chk("reset.dut4_ctrl", 64'({ov4, ir4}), 64'b01);
        chk("reset.dut4_prod", prod4, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("vec%0d", i), tv[i].w, tv[i].o, tv[i].x, tv[i].y, tv[i].p, tv[i].r);
        end

        // Backpressure: DONE holds its outputs and ignores in_valid while out_ready is low.
        start_op(1, 2'b11, 32'hDEADBEEF, 32'h12345678);
        wait_done(1, lat);
        ep = ref_prod(2'b11, 32'hDEADBEEF, 32'h12345678);
        chk("bp.product", prod1, ep);
        hold_p = prod1;
        hold_r = res1;
        for (int i = 0; i < 5; i++) begin
            a   = $urandom;
            b   = $urandom;
            op  = 2'($urandom);
            iv1 = ~iv1;
            tick();
            chk($sformatf("bp%0d.product", i), prod1, hold_p);
            chk($sformatf("bp%0d.result", i), 64'(res1), 64'(hold_r));
            chk($sformatf("bp%0d.ctrl", i), 64'({ov1, ir1}), 64'b10);
        end
        iv1 = 1'b0;
        take_result(1);

        // Flush on CALC cycle 10 aborts the op with no out_valid pulse.
        start_op(1, 2'b00, 32'd9, 32'd11);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.ctrl", 64'({ov1, ir1}), 64'b01);
        pulses = 0;
        repeat (40) begin
            tick();
            if (ov1) pulses++;
        end
        chk("flush.no_out_valid", 64'(pulses), 64'd0);

        // Flush beats in_valid in IDLE: nothing is accepted.
        iv1   = 1'b1;
        flush = 1'b1;
        tick();
        iv1   = 1'b0;
        flush = 1'b0;
        chk("flush_prio.ready", 64'(ir1), 64'd1);
        pulses = 0;
        repeat (40) begin
            tick();
            if (ov1) pulses++;
        end
        chk("flush_prio.no_out_valid", 64'(pulses), 64'd0);

        // Asynchronous reset in the middle of CALC.
        start_op(1, 2'b11, 32'hFFFFFFFF, 32'd3);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.ctrl", 64'({ov1, ir1}), 64'b01);
        chk("rst_mid.product", prod1, 64'h0);
        chk("rst_mid.result", 64'(res1), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            tick();
            if (ov1) pulses++;
        end
        chk("rst_mid.no_out_valid", 64'(pulses), 64'd0);
        run_check("after_abort", 1, 2'b00, 32'd3, 32'd5, 64'd15, 32'd15);

        // Random ops on both instances against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            case ($urandom_range(0, 5))
                0: rx = 32'h80000000;
                1: rx = 32'hFFFFFFFF;
                2: rx = 32'd0;
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: ry = 32'h80000000;
                1: ry = 32'hFFFFFFFF;
                2: ry = 32'd1;
                default: ry = $urandom;
            endcase
            ep = ref_prod(ro, rx, ry);
            run_check($sformatf("rnd%0d", i), (i % 2 == 1) ? 4 : 1, ro, rx, ry, ep, ref_res(ro, ep));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
